// File: rtl/wb_pkg.sv
// Shared writeback/register-file definitions: widths, index type, x0 constant.
`timescale 1ns/1ps
package wb_pkg;
  localparam int unsigned XLEN       = 64;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  function automatic logic is_commit(input logic regwrite, input reg_addr_t rd);
    return regwrite && (rd != REG_ZERO);
  endfunction
endpackage

// File: rtl/wb_regfile_array.sv
// Register storage: one synchronous write port, two combinational read ports,
// asynchronous active-high clear of every entry.
`timescale 1ns/1ps
module wb_regfile_array
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = wb_pkg::XLEN,
  parameter int unsigned NREGS = wb_pkg::NREGS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  reg_addr_t       waddr,
  input  logic [XLEN-1:0] wdata,
  input  reg_addr_t       raddr1,
  input  reg_addr_t       raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (32'(waddr) < NREGS)) begin
      mem[waddr] <= wdata;
    end
  end

  // Indices beyond NREGS (only possible when NREGS < 32) read as zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (32'(raddr1) < NREGS) rdata1 = mem[raddr1];
    if (32'(raddr2) < NREGS) rdata2 = mem[raddr2];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + architectural register file with commit counter.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through to the read ports.
`timescale 1ns/1ps
module wb_regfile
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = wb_pkg::XLEN,
  parameter int unsigned NREGS = wb_pkg::NREGS,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwb_regwrite,
  input  logic             memwb_memtoreg,
  input  logic [XLEN-1:0]  memwb_read_data,
  input  logic [XLEN-1:0]  memwb_result,
  input  reg_addr_t        memwb_rd,
  input  reg_addr_t        rs1_addr,
  input  reg_addr_t        rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] wb_commit_cnt
);

  logic            commit;
  logic [XLEN-1:0] arr_rs1;
  logic [XLEN-1:0] arr_rs2;

  assign wb_data = memwb_memtoreg ? memwb_read_data : memwb_result;
  assign commit  = is_commit(memwb_regwrite, memwb_rd);

  wb_regfile_array #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .we     (commit),
    .waddr  (memwb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (arr_rs1),
    .rdata2 (arr_rs2)
  );

  always_comb begin
    rs1_data = arr_rs1;
    rs2_data = arr_rs2;
`ifdef REGFILE_BYPASS_EN
    // Bypass is suppressed during reset so the read ports stay zero.
    if (!reset && commit && (memwb_rd == rs1_addr)) rs1_data = wb_data;
    if (!reset && commit && (memwb_rd == rs2_addr)) rs2_data = wb_data;
`endif
    if (rs1_addr == REG_ZERO) rs1_data = '0;
    if (rs2_addr == REG_ZERO) rs2_data = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_commit_cnt <= '0;
    end else if (commit) begin
      wb_commit_cnt <= wb_commit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expected responses from a
// behavioural register model, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwb_regwrite = 1'b0;
  logic        memwb_memtoreg = 1'b0;
  logic [63:0] memwb_read_data = '0;
  logic [63:0] memwb_result = '0;
  logic [4:0]  memwb_rd = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;

  logic [63:0] rs1_data, rs2_data, wb_data;
  logic [31:0] wb_commit_cnt;
  logic [63:0] rs1_data4, rs2_data4, wb_data4;
  logic [3:0]  wb_commit_cnt4;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .memwb_regwrite(memwb_regwrite), .memwb_memtoreg(memwb_memtoreg),
    .memwb_read_data(memwb_read_data), .memwb_result(memwb_result),
    .memwb_rd(memwb_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data),
    .wb_commit_cnt(wb_commit_cnt)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .memwb_regwrite(memwb_regwrite), .memwb_memtoreg(memwb_memtoreg),
    .memwb_read_data(memwb_read_data), .memwb_result(memwb_result),
    .memwb_rd(memwb_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data4), .rs2_data(rs2_data4), .wb_data(wb_data4),
    .wb_commit_cnt(wb_commit_cnt4)
  );

  typedef struct {
    string       tag;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] wb;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] ref_regs [32];
  int unsigned ref_cnt;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  bit          drv_done = 1'b0;

  function automatic logic [63:0] model_read(input logic [4:0] a, input bit rst,
                                             input bit wr, input logic [4:0] rd,
                                             input logic [63:0] wv);
    if (rst || a == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (wr && rd != 5'd0 && rd == a) return wv;
`endif
    return ref_regs[a];
  endfunction

  task automatic cycle(input string tag, input bit rst, input bit rw, input bit mtr,
                       input logic [63:0] rdd, input logic [63:0] res,
                       input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    logic [63:0] wv;
    @(posedge clk);
    #2;
    reset = rst;
    memwb_regwrite = rw;
    memwb_memtoreg = mtr;
    memwb_read_data = rdd;
    memwb_result = res;
    memwb_rd = rd;
    rs1_addr = a1;
    rs2_addr = a2;
    if (rst) begin
      foreach (ref_regs[i]) ref_regs[i] = 64'd0;
      ref_cnt = 0;
    end
    wv = mtr ? rdd : res;
    e.tag  = tag;
    e.rs1  = model_read(a1, rst, rw, rd, wv);
    e.rs2  = model_read(a2, rst, rw, rd, wv);
    e.wb   = wv;
    e.cnt  = 32'(ref_cnt);
    e.cnt4 = 4'(ref_cnt % 16);
    sb_q.push_back(e);
    // The write lands at the coming edge; later expectations see it.
    if (!rst && rw && rd != 5'd0) begin
      ref_regs[rd] = wv;
      ref_cnt++;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %h want %h at %0t", nm, got, want, $time);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.tag, ".rs1"},  rs1_data,  e.rs1);
      chk({e.tag, ".rs2"},  rs2_data,  e.rs2);
      chk({e.tag, ".wb"},   wb_data,   e.wb);
      chk({e.tag, ".cnt"},  64'(wb_commit_cnt), 64'(e.cnt));
      chk({e.tag, ".rs1_4"}, rs1_data4, e.rs1);
      chk({e.tag, ".rs2_4"}, rs2_data4, e.rs2);
      chk({e.tag, ".wb_4"},  wb_data4,  e.wb);
      chk({e.tag, ".cnt4"}, 64'(wb_commit_cnt4), 64'(e.cnt4));
    end
  end

  initial begin
    logic [4:0] rd, a1, a2;
    foreach (ref_regs[i]) ref_regs[i] = 64'd0;
    ref_cnt = 0;

    cycle("reset",     1, 0, 0, 64'd0, 64'd0, 5'd0, 5'd1, 5'd2);
    cycle("idle",      0, 0, 0, 64'd1, 64'd2, 5'd4, 5'd4, 5'd0);
    cycle("wr_x5",     0, 1, 0, 64'd0, 64'h55, 5'd5, 5'd0, 5'd0);
    cycle("wr_x31",    0, 1, 1, 64'h3131, 64'h0, 5'd31, 5'd5, 5'd0);
    cycle("rd_5_31",   0, 0, 0, 64'd0, 64'd0, 5'd0, 5'd5, 5'd31);
    cycle("async_rst", 1, 0, 0, 64'd0, 64'd0, 5'd0, 5'd5, 5'd31);
    cycle("rst_drop",  1, 1, 0, 64'd0, 64'h777, 5'd12, 5'd12, 5'd12);
    cycle("post_rst",  0, 1, 0, 64'd0, 64'h1313, 5'd13, 5'd12, 5'd0);
    cycle("first_wr",  0, 0, 0, 64'd0, 64'd0, 5'd0, 5'd13, 5'd12);
    cycle("wr_x7",     0, 1, 0, 64'd0, 64'hDEAD_BEEF_0000_0001, 5'd7, 5'd0, 5'd0);
    cycle("rd_x7",     0, 0, 0, 64'd0, 64'd0, 5'd0, 5'd7, 5'd7);
    cycle("ld_x3",     0, 1, 1, 64'h1234, 64'h9999, 5'd3, 5'd0, 5'd0);
    cycle("rd_x3",     0, 0, 0, 64'd0, 64'd0, 5'd0, 5'd3, 5'd7);
    cycle("wr_x0",     0, 1, 0, 64'd0, 64'hFFFF, 5'd0, 5'd0, 5'd0);
    cycle("rd_x0",     0, 0, 0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd3);
    cycle("x9_init",   0, 1, 0, 64'd0, 64'd5, 5'd9, 5'd0, 5'd0);
    cycle("x9_same",   0, 1, 0, 64'd0, 64'hA, 5'd9, 5'd9, 5'd9);
    cycle("x9_after",  0, 0, 0, 64'd0, 64'd0, 5'd0, 5'd9, 5'd9);
    cycle("ign_rw0",   0, 0, 1, 64'hBAD, 64'hBAD, 5'd9, 5'd9, 5'd0);

    for (int i = 0; i < 18; i++)
      cycle("wrap", 0, 1, 0, 64'd0, 64'(i + 100), 5'(1 + (i % 31)), 5'(i % 32), 5'd1);

    for (int i = 0; i < 300; i++) begin
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      cycle("rand", ($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, rd, a1, a2);
    end
    drv_done = 1'b1;
  end

  initial begin
    wait (drv_done);
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending %0d want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time %0t want driver done", $time);
    $fatal(1);
  end

endmodule
